// File: rtl/npc_mem_pkg.sv
// Shared types and constants for the NPC memory responder: FSM state encoding,
// default base address and LFSR parameters for the optional random-delay mode.
package npc_mem_pkg;

    typedef enum logic [1:0] {
        StIdle,
        StWait,
        StResp
    } state_e;

    localparam logic [31:0] DefaultBase = 32'h8000_0000;

    // Fibonacci taps 8,6,5,4 expressed as bit positions 7,5,4,3
    localparam logic [7:0] LfsrSeed = 8'hA5;
    localparam logic [7:0] LfsrTaps = 8'b1011_1000;

    // Wide enough for LATENCY (<=15) plus the random extra delay (<=3)
    localparam int unsigned CntW = 5;

    function automatic logic [3:0] lane_mask(logic [3:0] wmask, logic [1:0] byte_off);
        logic [3:0] m;
        m = wmask << byte_off;
        return m;
    endfunction

endpackage

// File: rtl/npc_mem_responder_if.sv
// Request/response channel bundle between the NPC load/store port (master)
// and the memory responder (slave).
interface npc_mem_responder_if;

    logic        req_valid;
    logic        req_ready;
    logic        req_wen;
    logic [31:0] req_addr;
    logic [31:0] req_wdata;
    logic [3:0]  req_wmask;
    logic        resp_valid;
    logic        resp_ready;
    logic [31:0] resp_rdata;
    logic        resp_err;

    modport master (
        output req_valid, req_wen, req_addr, req_wdata, req_wmask, resp_ready,
        input  req_ready, resp_valid, resp_rdata, resp_err
    );

    modport slave (
        input  req_valid, req_wen, req_addr, req_wdata, req_wmask, resp_ready,
        output req_ready, resp_valid, resp_rdata, resp_err
    );

endinterface

// File: rtl/npc_lfsr8.sv
// 8-bit Fibonacci LFSR (taps 8,6,5,4), reseeded on reset, advancing every cycle.
module npc_lfsr8
    import npc_mem_pkg::*;
(
    input  logic       clk,
    input  logic       reset,
    output logic [7:0] value
);

    logic [7:0] lfsr_q;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            lfsr_q <= LfsrSeed;
        end else begin
            lfsr_q <= {lfsr_q[6:0], ^(lfsr_q & LfsrTaps)};
        end
    end

    assign value = lfsr_q;

endmodule

// File: rtl/npc_mem_responder.sv
// Cycle-accurate memory slave for the NPC load/store port with programmable latency.
// Define NPC_MEM_RAND_DELAY_EN to add a pseudo-random 0..3 cycle extra delay per request.
module npc_mem_responder
    import npc_mem_pkg::*;
#(
    parameter int unsigned DEPTH   = 1024,
    parameter logic [31:0] BASE    = DefaultBase,
    parameter int unsigned LATENCY = 1
) (
    input logic                clk,
    input logic                reset,
    npc_mem_responder_if.slave bus
);

    localparam int unsigned AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    state_e          state_q;
    logic [CntW-1:0] cnt_q;
    logic            wen_q;
    logic [31:0]     addr_q;
    logic [31:0]     wdata_q;
    logic [3:0]      wmask_q;
    logic            req_ready_q;
    logic            resp_valid_q;
    logic [31:0]     rdata_q;
    logic            err_q;

    // Contents survive reset; zero only at time zero
    logic [31:0] mem_q [DEPTH] = '{default: 32'h0};

    logic [CntW-1:0] delay;

`ifdef NPC_MEM_RAND_DELAY_EN
    logic [7:0] lfsr_value;
    logic       unused_lfsr;

    npc_lfsr8 u_lfsr (
        .clk   (clk),
        .reset (reset),
        .value (lfsr_value)
    );

    assign delay       = CntW'(LATENCY) + CntW'(lfsr_value[1:0]);
    assign unused_lfsr = ^lfsr_value[7:2];
`else
    assign delay = CntW'(LATENCY);
`endif

    // The transaction being serviced: live inputs at accept, captured copy afterwards
    logic        cur_wen;
    logic [31:0] cur_addr;
    logic [31:0] cur_wdata;
    logic [3:0]  cur_wmask;

    always_comb begin
        if (state_q == StIdle) begin
            cur_wen   = bus.req_wen;
            cur_addr  = bus.req_addr;
            cur_wdata = bus.req_wdata;
            cur_wmask = bus.req_wmask;
        end else begin
            cur_wen   = wen_q;
            cur_addr  = addr_q;
            cur_wdata = wdata_q;
            cur_wmask = wmask_q;
        end
    end

    logic [30:0]   word_off;
    logic          in_range;
    logic [AW-1:0] mem_idx;
    logic [4:0]    byte_sh;
    logic [3:0]    lanes;
    logic [31:0]   wdata_sh;
    logic [31:0]   rdata_sh;
    logic [31:0]   resp_data;
    logic          accept;
    logic          go_resp;

    // Sign bit of the 31-bit difference flags addr < BASE without wrap-around
    assign word_off  = {1'b0, cur_addr[31:2]} - {1'b0, BASE[31:2]};
    assign in_range  = ~word_off[30] && ({2'b00, word_off[29:0]} < DEPTH);
    assign mem_idx   = word_off[AW-1:0];
    assign byte_sh   = {cur_addr[1:0], 3'b000};
    assign lanes     = lane_mask(cur_wmask, cur_addr[1:0]);
    assign wdata_sh  = cur_wdata << byte_sh;
    assign rdata_sh  = mem_q[mem_idx] >> byte_sh;
    assign resp_data = (!cur_wen && in_range) ? rdata_sh : 32'h0;

    assign accept  = (state_q == StIdle) && bus.req_valid;
    assign go_resp = (accept && (delay == '0)) ||
                     ((state_q == StWait) && (cnt_q == CntW'(1)));

    always_ff @(posedge clk) begin
        if (!reset && go_resp && cur_wen && in_range) begin
            for (int b = 0; b < 4; b++) begin
                if (lanes[b]) begin
                    mem_q[mem_idx][8*b +: 8] <= wdata_sh[8*b +: 8];
                end
            end
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q      <= StIdle;
            cnt_q        <= '0;
            wen_q        <= 1'b0;
            addr_q       <= 32'h0;
            wdata_q      <= 32'h0;
            wmask_q      <= 4'h0;
            req_ready_q  <= 1'b1;
            resp_valid_q <= 1'b0;
            rdata_q      <= 32'h0;
            err_q        <= 1'b0;
        end else begin
            unique case (state_q)
                StIdle: begin
                    if (bus.req_valid) begin
                        wen_q       <= bus.req_wen;
                        addr_q      <= bus.req_addr;
                        wdata_q     <= bus.req_wdata;
                        wmask_q     <= bus.req_wmask;
                        req_ready_q <= 1'b0;
                        if (go_resp) begin
                            state_q      <= StResp;
                            resp_valid_q <= 1'b1;
                            rdata_q      <= resp_data;
                            err_q        <= ~in_range;
                        end else begin
                            state_q <= StWait;
                            cnt_q   <= delay;
                        end
                    end
                end
                StWait: begin
                    cnt_q <= cnt_q - CntW'(1);
                    if (go_resp) begin
                        state_q      <= StResp;
                        resp_valid_q <= 1'b1;
                        rdata_q      <= resp_data;
                        err_q        <= ~in_range;
                    end
                end
                StResp: begin
                    if (bus.resp_ready) begin
                        state_q      <= StIdle;
                        resp_valid_q <= 1'b0;
                        req_ready_q  <= 1'b1;
                    end
                end
                default: begin
                    state_q <= StIdle;
                end
            endcase
        end
    end

    assign bus.req_ready  = req_ready_q;
    assign bus.resp_valid = resp_valid_q;
    assign bus.resp_rdata = rdata_q;
    assign bus.resp_err   = err_q;

endmodule
